// File: rtl/eth_frame_checker_if.sv
// Byte-stream bus for eth_frame_checker: data/control in, verdict flags and counters out.
// Ports: data, control (master drives); flags, frame_done, counters (fcs_valid with ETH_FRAME_CHECKER_FCS_EN).
interface eth_frame_checker_if #(
    parameter int CNT_W = 8
);
    logic [7:0]       data;
    logic             control;
    logic             preamble_valid;
    logic             dst_addr_valid;
    logic             src_addr_valid;
    logic             type_length_valid;
    logic             packet_size_valid;
    logic             frame_done;
    logic [CNT_W-1:0] valid_packet_counter;
    logic [CNT_W-1:0] error_packet_counter;
`ifdef ETH_FRAME_CHECKER_FCS_EN
    logic             fcs_valid;
`endif

    modport master (
`ifdef ETH_FRAME_CHECKER_FCS_EN
        input  fcs_valid,
`endif
        output data,
        output control,
        input  preamble_valid,
        input  dst_addr_valid,
        input  src_addr_valid,
        input  type_length_valid,
        input  packet_size_valid,
        input  frame_done,
        input  valid_packet_counter,
        input  error_packet_counter
    );

    modport slave (
`ifdef ETH_FRAME_CHECKER_FCS_EN
        output fcs_valid,
`endif
        input  data,
        input  control,
        output preamble_valid,
        output dst_addr_valid,
        output src_addr_valid,
        output type_length_valid,
        output packet_size_valid,
        output frame_done,
        output valid_packet_counter,
        output error_packet_counter
    );
endinterface

// File: rtl/eth_frame_checker.sv
// Ethernet frame checker: walks preamble/DST/SRC/TYPE/payload, flags each field, counts verdicts.
// Ports: clk, reset (async active-low), bus (slave). Optional CRC-32 FCS check: ETH_FRAME_CHECKER_FCS_EN.
module eth_frame_checker #(
    parameter logic [47:0] STATION_ADDR  = 48'h0200_0000_0001,
    parameter int          MIN_FRAME_LEN = 64,
    parameter int          MAX_FRAME_LEN = 1518,
    parameter int          CNT_W         = 8,
    parameter bit          ACCEPT_MCAST  = 1'b0
) (
    input logic             clk,
    input logic             reset,
    eth_frame_checker_if.slave bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_DST  = 3'd2;
    localparam logic [2:0] S_SRC  = 3'd3;
    localparam logic [2:0] S_TYPE = 3'd4;
    localparam logic [2:0] S_PAY  = 3'd5;
    localparam logic [2:0] S_DROP = 3'd6;

    localparam logic [10:0] LEN_SAT = 11'(MAX_FRAME_LEN + 1);
    localparam logic [10:0] MIN_L   = 11'(MIN_FRAME_LEN);
    localparam logic [10:0] MAX_L   = 11'(MAX_FRAME_LEN);

    logic [2:0]       state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic [10:0]      len_q, len_d;
    logic             dmatch_q, dmatch_d;
    logic             dbc_q, dbc_d;
    logic             dgrp_q, dgrp_d;
    logic             sind_q, sind_d;
    logic             snz_q, snz_d;
    logic [7:0]       tlhi_q, tlhi_d;
    logic             pre_q, pre_d;
    logic             dst_q, dst_d;
    logic             src_q, src_d;
    logic             tl_q, tl_d;
    logic             size_q, size_d;
    logic             done_q, done_d;
    // armed_q: a control=0 cycle was seen since reset, so a frame start is trustworthy
    logic             armed_q, armed_d;
    // silent_q: frame cut by reset; drop its tail without a verdict
    logic             silent_q, silent_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;

    logic [7:0]       sta_byte;
    logic             m_now, b_now, g_now, ind_now, nz_now;
    logic [15:0]      tl_val;
    logic [10:0]      len_inc;
    logic             size_ok;
    logic             accept;
    logic             in_body;

`ifdef ETH_FRAME_CHECKER_FCS_EN
    logic [31:0] crc_q, crc_d;
    logic        fcs_q, fcs_d;
    logic [31:0] crc_rev;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            crc_rev[i] = crc_q[31-i];
        end
    end
`endif

    always_comb begin
        sta_byte = 8'(STATION_ADDR >> {3'd5 - fcnt_q, 3'b000});
        m_now    = ((fcnt_q == 3'd0) || dmatch_q) && (bus.data == sta_byte);
        b_now    = ((fcnt_q == 3'd0) || dbc_q) && (bus.data == 8'hFF);
        g_now    = (fcnt_q == 3'd0) ? bus.data[0] : dgrp_q;
        ind_now  = (fcnt_q == 3'd0) ? ~bus.data[0] : sind_q;
        nz_now   = ((fcnt_q != 3'd0) && snz_q) || (|bus.data);
        tl_val   = {tlhi_q, bus.data};
        len_inc  = (len_q == LEN_SAT) ? len_q : len_q + 11'd1;
        size_ok  = (len_q >= MIN_L) && (len_q <= MAX_L);
        in_body  = (state_q == S_DST) || (state_q == S_SRC) ||
                   (state_q == S_TYPE) || (state_q == S_PAY);
    end

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        len_d    = len_q;
        dmatch_d = dmatch_q;
        dbc_d    = dbc_q;
        dgrp_d   = dgrp_q;
        sind_d   = sind_q;
        snz_d    = snz_q;
        tlhi_d   = tlhi_q;
        pre_d    = pre_q;
        dst_d    = dst_q;
        src_d    = src_q;
        tl_d     = tl_q;
        size_d   = size_q;
        done_d   = 1'b0;
        armed_d  = armed_q;
        silent_d = silent_q;
        vcnt_d   = vcnt_q;
        ecnt_d   = ecnt_q;
        accept   = 1'b0;
`ifdef ETH_FRAME_CHECKER_FCS_EN
        crc_d    = crc_q;
        fcs_d    = fcs_q;
        if (bus.control && in_body) begin
            crc_d = crc_byte(crc_q, bus.data);
        end
`endif
        if (state_q != S_IDLE && !bus.control) begin
            state_d  = S_IDLE;
            armed_d  = 1'b1;
            silent_d = 1'b0;
            if (!silent_q) begin
                done_d = 1'b1;
                size_d = (state_q == S_PAY) && size_ok;
                accept = pre_q & dst_q & src_q & tl_q & size_d;
`ifdef ETH_FRAME_CHECKER_FCS_EN
                fcs_d  = (state_q == S_PAY) && (crc_rev == 32'hC704_DD7B);
                accept = accept & fcs_d;
`endif
                if (accept) begin
                    vcnt_d = (&vcnt_q) ? vcnt_q : vcnt_q + 1'b1;
                end else begin
                    ecnt_d = (&ecnt_q) ? ecnt_q : ecnt_q + 1'b1;
                end
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (!bus.control) begin
                        armed_d = 1'b1;
                    end else begin
                        pre_d  = 1'b0;
                        dst_d  = 1'b0;
                        src_d  = 1'b0;
                        tl_d   = 1'b0;
                        size_d = 1'b0;
`ifdef ETH_FRAME_CHECKER_FCS_EN
                        fcs_d  = 1'b0;
`endif
                        len_d  = 11'd0;
                        fcnt_d = 3'd1;
                        if (!armed_q) begin
                            state_d  = S_DROP;
                            silent_d = 1'b1;
                        end else if (bus.data == 8'h55) begin
                            state_d = S_PRE;
                        end else begin
                            state_d = S_DROP;
                        end
                    end
                end
                S_PRE: begin
                    if (fcnt_q == 3'd7) begin
                        if (bus.data == 8'hD5) begin
                            state_d = S_DST;
                            pre_d   = 1'b1;
                            fcnt_d  = 3'd0;
`ifdef ETH_FRAME_CHECKER_FCS_EN
                            crc_d   = 32'hFFFF_FFFF;
`endif
                        end else begin
                            state_d = S_DROP;
                        end
                    end else if (bus.data == 8'h55) begin
                        fcnt_d = fcnt_q + 3'd1;
                    end else begin
                        state_d = S_DROP;
                    end
                end
                S_DST: begin
                    len_d    = len_inc;
                    dmatch_d = m_now;
                    dbc_d    = b_now;
                    dgrp_d   = g_now;
                    if (fcnt_q == 3'd5) begin
                        dst_d   = m_now | b_now | (ACCEPT_MCAST & g_now);
                        state_d = S_SRC;
                        fcnt_d  = 3'd0;
                    end else begin
                        fcnt_d = fcnt_q + 3'd1;
                    end
                end
                S_SRC: begin
                    len_d  = len_inc;
                    sind_d = ind_now;
                    snz_d  = nz_now;
                    if (fcnt_q == 3'd5) begin
                        src_d   = ind_now & nz_now;
                        state_d = S_TYPE;
                        fcnt_d  = 3'd0;
                    end else begin
                        fcnt_d = fcnt_q + 3'd1;
                    end
                end
                S_TYPE: begin
                    len_d = len_inc;
                    if (fcnt_q == 3'd0) begin
                        tlhi_d = bus.data;
                        fcnt_d = 3'd1;
                    end else begin
                        tl_d    = (tl_val <= 16'd1500) || (tl_val >= 16'h0600);
                        state_d = S_PAY;
                    end
                end
                S_PAY: begin
                    len_d = len_inc;
                end
                S_DROP: begin
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            fcnt_q   <= 3'd0;
            len_q    <= 11'd0;
            dmatch_q <= 1'b0;
            dbc_q    <= 1'b0;
            dgrp_q   <= 1'b0;
            sind_q   <= 1'b0;
            snz_q    <= 1'b0;
            tlhi_q   <= 8'd0;
            pre_q    <= 1'b0;
            dst_q    <= 1'b0;
            src_q    <= 1'b0;
            tl_q     <= 1'b0;
            size_q   <= 1'b0;
            done_q   <= 1'b0;
            armed_q  <= 1'b0;
            silent_q <= 1'b0;
            vcnt_q   <= '0;
            ecnt_q   <= '0;
`ifdef ETH_FRAME_CHECKER_FCS_EN
            crc_q    <= 32'hFFFF_FFFF;
            fcs_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            len_q    <= len_d;
            dmatch_q <= dmatch_d;
            dbc_q    <= dbc_d;
            dgrp_q   <= dgrp_d;
            sind_q   <= sind_d;
            snz_q    <= snz_d;
            tlhi_q   <= tlhi_d;
            pre_q    <= pre_d;
            dst_q    <= dst_d;
            src_q    <= src_d;
            tl_q     <= tl_d;
            size_q   <= size_d;
            done_q   <= done_d;
            armed_q  <= armed_d;
            silent_q <= silent_d;
            vcnt_q   <= vcnt_d;
            ecnt_q   <= ecnt_d;
`ifdef ETH_FRAME_CHECKER_FCS_EN
            crc_q    <= crc_d;
            fcs_q    <= fcs_d;
`endif
        end
    end

    assign bus.preamble_valid       = pre_q;
    assign bus.dst_addr_valid       = dst_q;
    assign bus.src_addr_valid       = src_q;
    assign bus.type_length_valid    = tl_q;
    assign bus.packet_size_valid    = size_q;
    assign bus.frame_done           = done_q;
    assign bus.valid_packet_counter = vcnt_q;
    assign bus.error_packet_counter = ecnt_q;
`ifdef ETH_FRAME_CHECKER_FCS_EN
    assign bus.fcs_valid            = fcs_q;
`endif

endmodule
